// File: rtl/glitch_sequencer.sv
// glitch_sequencer: trigger scheduler feeding the pwm_glitch stage.
// Waits in ARMED for a rising trigger edge, counts cur_delay cycles, drives
// a glitch request for the latched width, then sits out HOLDOFF dead cycles.
// Optional feature macro: GLITCH_SEQ_SWEEP_EN
//   defined   : cur_delay sweeps DELAY_MIN..DELAY_MAX by DELAY_STEP, done
//               pulses on wrap, HOLD exits back to ARMED (auto re-arm).
//   undefined : cur_delay fixed at DELAY_MIN, done tied low, HOLD exits to
//               IDLE (single shot, arm required for the next attempt).
// Handshake: arm is a one-cycle request honoured only in IDLE; abort is a
// level that forces IDLE from any state and wins over arm; trigger is a
// synchronous level whose rising edge is only acted on in ARMED.
module glitch_sequencer #(
   parameter int DELAY_W    = 16,
   parameter int WIDTH_W    = 8,
   parameter int DELAY_MIN  = 2,
   parameter int DELAY_MAX  = 100,
   parameter int DELAY_STEP = 1,
   parameter int HOLDOFF    = 1000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               arm,
   input  logic               abort,
   input  logic               trigger,
   input  logic [WIDTH_W-1:0] width,
   output logic               glitch,
   output logic               busy,
   output logic [7:0]         attempt,
   output logic               done,
   output logic [2:0]         dbg_state
);

   localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARMED = 3'd1,
      S_DELAY = 3'd2,
      S_FIRE  = 3'd3,
      S_HOLD  = 3'd4
   } state_t;

   // Reject configurations the counters cannot honour.
   if ((DELAY_MIN > DELAY_MAX) || (DELAY_STEP < 1) || (HOLDOFF < 1)) begin : g_bad_cfg
      $error("glitch_sequencer: illegal delay/holdoff parameters");
   end

   state_t               r_state;
   logic                 r_trig_d;
   logic [DELAY_W-1:0]   r_dcnt;
   logic [WIDTH_W-1:0]   r_wcnt;
   logic [WIDTH_W-1:0]   r_wlat;
   logic [HOLD_W-1:0]    r_hcnt;
   logic                 r_glitch;
   logic                 r_busy;
   logic [7:0]           r_attempt;

   logic                 w_edge;
   logic [WIDTH_W-1:0]   w_width_eff;
   logic [DELAY_W-1:0]   w_cur_delay;
   logic                 w_delay_last;
   logic                 w_fire_last;
   logic                 w_hold_last;

`ifdef GLITCH_SEQ_SWEEP_EN
   logic [DELAY_W-1:0]   r_cur_delay;
   logic                 r_done;
   logic [DELAY_W:0]     w_sum;
   logic                 w_wrap;

   // Next sweep point is computed one bit wider so the overflow check is exact.
   assign w_sum       = {1'b0, r_cur_delay} + (DELAY_W+1)'(DELAY_STEP);
   assign w_wrap      = (w_sum > (DELAY_W+1)'(DELAY_MAX));
   assign w_cur_delay = r_cur_delay;
   assign done        = r_done;
`else
   assign w_cur_delay = DELAY_W'(DELAY_MIN);
   assign done        = 1'b0;
`endif

   assign w_edge       = trigger & ~r_trig_d;
   assign w_width_eff  = (width == '0) ? WIDTH_W'(1) : width;
   assign w_delay_last = (r_dcnt == w_cur_delay - DELAY_W'(1));
   assign w_fire_last  = (r_wcnt == r_wlat - WIDTH_W'(1));
   assign w_hold_last  = (r_hcnt == HOLD_W'(HOLDOFF - 1));

   assign glitch    = r_glitch;
   assign busy      = r_busy;
   assign attempt   = r_attempt;
   assign dbg_state = r_state;

   // Trigger history for rising-edge detection; clears to 0 so a trigger
   // already high at reset release counts as an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_trig_d <= 1'b0;
      else     r_trig_d <= trigger;
   end

   // Attempt sequencer: state, counters and all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_dcnt    <= '0;
         r_wcnt    <= '0;
         r_wlat    <= WIDTH_W'(1);
         r_hcnt    <= '0;
         r_glitch  <= 1'b0;
         r_busy    <= 1'b0;
         r_attempt <= '0;
`ifdef GLITCH_SEQ_SWEEP_EN
         r_cur_delay <= DELAY_W'(DELAY_MIN);
         r_done      <= 1'b0;
`endif
      end else begin
`ifdef GLITCH_SEQ_SWEEP_EN
         r_done <= 1'b0;
`endif
         if (abort) begin
            // Abort drops everything except the sweep position and attempt count.
            r_state  <= S_IDLE;
            r_glitch <= 1'b0;
            r_busy   <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (arm) begin
                     r_state <= S_ARMED;
                     r_busy  <= 1'b1;
                  end
               end
               S_ARMED: begin
                  if (w_edge) begin
                     r_wlat <= w_width_eff;
                     if (w_cur_delay == '0) begin
                        r_state  <= S_FIRE;
                        r_glitch <= 1'b1;
                        r_wcnt   <= '0;
                     end else begin
                        r_state <= S_DELAY;
                        r_dcnt  <= '0;
                     end
                  end
               end
               S_DELAY: begin
                  if (w_delay_last) begin
                     r_state  <= S_FIRE;
                     r_glitch <= 1'b1;
                     r_wcnt   <= '0;
                  end else begin
                     r_dcnt <= r_dcnt + DELAY_W'(1);
                  end
               end
               S_FIRE: begin
                  if (w_fire_last) begin
                     r_state  <= S_HOLD;
                     r_glitch <= 1'b0;
                     r_hcnt   <= '0;
                  end else begin
                     r_wcnt <= r_wcnt + WIDTH_W'(1);
                  end
               end
               S_HOLD: begin
                  if (w_hold_last) begin
                     r_attempt <= r_attempt + 8'd1;
`ifdef GLITCH_SEQ_SWEEP_EN
                     r_state <= S_ARMED;
                     if (w_wrap) begin
                        r_cur_delay <= DELAY_W'(DELAY_MIN);
                        r_done      <= 1'b1;
                     end else begin
                        r_cur_delay <= w_sum[DELAY_W-1:0];
                     end
`else
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
`endif
                  end else begin
                     r_hcnt <= r_hcnt + HOLD_W'(1);
                  end
               end
               default: begin
                  r_state  <= S_IDLE;
                  r_glitch <= 1'b0;
                  r_busy   <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_glitch_sequencer.sv
// tb_glitch_sequencer: directed bench for glitch_sequencer with small
// delay/holdoff parameters. Expected pulse timing, width, pulse count and
// done count are pushed to exp_q before each trigger edge and popped when
// the observed pulse has been measured. Works with or without
// GLITCH_SEQ_SWEEP_EN defined.
module tb_glitch_sequencer;

  localparam int DMIN  = 2;
  localparam int DMAX  = 4;
  localparam int DSTEP = 2;
  localparam int HOLD  = 3;
  localparam int WW    = 8;
`ifdef GLITCH_SEQ_SWEEP_EN
  localparam int SWEEP = 1;
`else
  localparam int SWEEP = 0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic          trigger = 1'b0;
  logic [WW-1:0] width = '0;
  logic          glitch;
  logic          busy;
  logic [7:0]    attempt;
  logic          done;
  logic [2:0]    dbg_state;

  glitch_sequencer #(
    .DELAY_W(16), .WIDTH_W(WW), .DELAY_MIN(DMIN), .DELAY_MAX(DMAX),
    .DELAY_STEP(DSTEP), .HOLDOFF(HOLD)
  ) dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .trigger(trigger),
    .width(width), .glitch(glitch), .busy(busy), .attempt(attempt),
    .done(done), .dbg_state(dbg_state)
  );

  // scoreboard
  logic [15:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int m_delay = DMIN;
  int m_att = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_pop(input string tag, input int obs);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(obs), 32'(e));
    end
  endtask

  // reference model of the sweep position
  function automatic int model_done(input int d);
    return (SWEEP != 0 && (d + DSTEP > DMAX)) ? 1 : 0;
  endfunction

  function automatic int model_next(input int d);
    if (SWEEP == 0) return DMIN;
    return (d + DSTEP > DMAX) ? DMIN : d + DSTEP;
  endfunction

  // driver tasks (all called in the phase just after a rising edge)
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    step();
    arm = 1'b0;
    step();
  endtask

  // One full attempt: raise trigger now (cycle T), then sample every
  // negedge. Offset k counts cycles after T.
  task automatic run_attempt(input int w_in, input int exp_d, input int exp_w,
                             input int exp_done, input int att_before,
                             input int n_req, input bit bounce);
    int rise, len, pulses, done_n, end_k, n;
    logic prev;
    end_k = 1 + exp_d + exp_w + HOLD;
    n = (n_req == 0) ? end_k + 4 : n_req;
    exp_q.push_back(16'(1 + exp_d));
    exp_q.push_back(16'(exp_w));
    exp_q.push_back(16'd1);
    exp_q.push_back(16'(exp_done));
    rise = -1; len = 0; pulses = 0; done_n = 0; prev = 1'b0;
    width = WW'(w_in);
    trigger = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (glitch === 1'b1) begin
        if (prev !== 1'b1) begin
          pulses++;
          if (rise < 0) rise = k;
        end
        len++;
      end
      prev = glitch;
      if (done === 1'b1) done_n++;
      if (k == 1) chk("busy_in_delay", 32'(busy), 32'd1);
      if (k == end_k - 1) chk("attempt_before_exit", 32'(attempt), 32'(att_before % 256));
      if (k == end_k) begin
        chk("attempt_after_exit", 32'(attempt), 32'((att_before + 1) % 256));
        chk("busy_after_exit", 32'(busy), 32'(SWEEP));
      end
      @(posedge clk);
      #1;
      if (bounce && k == 0) trigger = 1'b0;
      if (bounce && k == 1) trigger = 1'b1;
    end
    chk_pop("glitch_rise_offset", rise);
    chk_pop("glitch_length", len);
    chk_pop("glitch_pulse_count", pulses);
    chk_pop("done_count", done_n);
    trigger = 1'b0;
    step();
  endtask

  task automatic full_attempt(input int w_in, input int n_req, input bit bounce);
    int ew;
    ew = (w_in == 0) ? 1 : w_in;
    arm_pulse();
    run_attempt(w_in, m_delay, ew, model_done(m_delay), m_att, n_req, bounce);
    m_delay = model_next(m_delay);
    m_att++;
  endtask

  // watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int cnt;
    // reset state
    #2;
    chk("rst_glitch", 32'(glitch), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_attempt", 32'(attempt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    step();
    rst = 1'b0;
    step();

    // 1: reset in the middle of FIRE drops glitch at once, nothing counted
    arm_pulse();
    chk("armed_busy", 32'(busy), 32'd1);
    width = WW'(3);
    trigger = 1'b1;
    repeat (1 + DMIN + 1) step();
    chk("fire_glitch_high", 32'(glitch), 32'd1);
    chk("fire_state", 32'(dbg_state), 32'd3);
    rst = 1'b1;
    #1;
    chk("async_rst_glitch", 32'(glitch), 32'd0);
    trigger = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_attempt", 32'(attempt), 32'd0);
    chk("post_rst_done", 32'(done), 32'd0);
    chk("post_rst_glitch", 32'(glitch), 32'd0);

    // 2 and 3: two normal attempts (sweep wraps on the second)
    full_attempt(3, 0, 1'b0);
    full_attempt(3, 0, 1'b0);

    // 4: trigger held high for 50 cycles, plus an extra edge during DELAY
    full_attempt(2, 50, 1'b1);

    // 5: abort in the second FIRE cycle
    arm_pulse();
    width = WW'(5);
    trigger = 1'b1;
    repeat (1 + m_delay) step();
    chk("abort_fire1_glitch", 32'(glitch), 32'd1);
    step();
    chk("abort_fire2_glitch", 32'(glitch), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_glitch_low", 32'(glitch), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_attempt_kept", 32'(attempt), 32'(m_att % 256));
    exp_q.push_back(16'd0);
    cnt = 0;
    trigger = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (glitch === 1'b1) cnt++;
    end
    step();
    chk_pop("abort_no_more_glitch", cnt);
    chk("abort_stays_idle", 32'(dbg_state), 32'd0);
    // next attempt reuses the unchanged delay
    full_attempt(2, 0, 1'b0);

    // 6: width 0 behaves as width 1
    full_attempt(0, 0, 1'b0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
